// File: rtl/ts.sv
// Transmit scheduler: strict-priority pick of one eligible queue per round,
// single-cycle mb read, metadata forward, then wait for tx completion.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_ts_fifo_empty[3:0]    per-queue empty flags from mb
//   in_ts_gate_state[3:0]    per-queue gate open from GC
//   in_ts_md[7:0]            metadata from mb
//   in_ts_md_wr              metadata valid from mb
//   out_ts_q0..q3_rden       read enables to mb (one-hot, single cycle)
//   out_ts_md[7:0]           metadata to transmitter
//   out_ts_md_wr             metadata valid pulse to transmitter
//   out_ts_qid[1:0]          queue index of forwarded metadata
//   in_ts_tx_done            transmitter finished pulse
//   out_ts_busy              high outside IDLE
//   out_ts_timeout_err       sticky metadata timeout flag
//   out_ts_q0..q3_deq_cnt    per-queue forwarded packet counters
module ts #(
    parameter int MD_TIMEOUT = 4,
    parameter     PLATFORM   = "xilinx"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_ts_fifo_empty,
    input  logic [3:0]  in_ts_gate_state,
    input  logic [7:0]  in_ts_md,
    input  logic        in_ts_md_wr,
    output logic        out_ts_q0_rden,
    output logic        out_ts_q1_rden,
    output logic        out_ts_q2_rden,
    output logic        out_ts_q3_rden,
    output logic [7:0]  out_ts_md,
    output logic        out_ts_md_wr,
    output logic [1:0]  out_ts_qid,
    input  logic        in_ts_tx_done,
    output logic        out_ts_busy,
    output logic        out_ts_timeout_err,
    output logic [15:0] out_ts_q0_deq_cnt,
    output logic [15:0] out_ts_q1_deq_cnt,
    output logic [15:0] out_ts_q2_deq_cnt,
    output logic [15:0] out_ts_q3_deq_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MD   = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [3:0] TMO_LIM = 4'(MD_TIMEOUT);

    // Platform string only selects vendor flavour; behaviour is identical.
    if (PLATFORM == "xilinx") begin : g_xilinx
    end else begin : g_generic
    end

    state_e      state_q;
    logic [1:0]  sel_q;
    logic [3:0]  tmo_q;
    logic [7:0]  md_q;
    logic        md_wr_q;
    logic [1:0]  qid_q;
    logic        terr_q;
    logic [15:0] cnt_q [4];

    logic [3:0]  elig;
    logic [1:0]  grant;
    logic        issue;
    logic [3:0]  rden;

    assign elig = in_ts_gate_state & ~in_ts_fifo_empty;

    // Lowest eligible index wins.
    always_comb begin
        grant = 2'd0;
        if (elig[0]) begin
            grant = 2'd0;
        end else if (elig[1]) begin
            grant = 2'd1;
        end else if (elig[2]) begin
            grant = 2'd2;
        end else if (elig[3]) begin
            grant = 2'd3;
        end
    end

    // Read enable exists only in the IDLE cycle that grants; rst_n gating
    // keeps all outputs low while reset is asserted.
    assign issue = rst_n & (state_q == IDLE) & (|elig);
    assign rden  = issue ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            tmo_q   <= 4'd0;
            md_q    <= 8'd0;
            md_wr_q <= 1'b0;
            qid_q   <= 2'd0;
            terr_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            md_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        sel_q   <= grant;
                        tmo_q   <= 4'd0;
                        state_q <= WAIT_MD;
                    end
                end
                WAIT_MD: begin
                    if (in_ts_md_wr) begin
                        md_q         <= in_ts_md;
                        qid_q        <= sel_q;
                        md_wr_q      <= 1'b1;
                        cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
                        state_q      <= WAIT_DONE;
                    end else if (tmo_q + 4'd1 == TMO_LIM) begin
                        // mb never answered: abandon the round
                        terr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                WAIT_DONE: begin
                    if (in_ts_tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_ts_q0_rden     = rden[0];
    assign out_ts_q1_rden     = rden[1];
    assign out_ts_q2_rden     = rden[2];
    assign out_ts_q3_rden     = rden[3];
    assign out_ts_md          = md_q;
    assign out_ts_md_wr       = md_wr_q;
    assign out_ts_qid         = qid_q;
    assign out_ts_busy        = (state_q != IDLE);
    assign out_ts_timeout_err = terr_q;
    assign out_ts_q0_deq_cnt  = cnt_q[0];
    assign out_ts_q1_deq_cnt  = cnt_q[1];
    assign out_ts_q2_deq_cnt  = cnt_q[2];
    assign out_ts_q3_deq_cnt  = cnt_q[3];

endmodule

// File: tb/tb_ts.sv
// Testbench for ts: round-level reference model with randomized
// gating, metadata, timeouts and tx_done delays.
module tb_ts;

    localparam int MDT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  empty;
    logic [3:0]  gate;
    logic [7:0]  md_i;
    logic        md_wr_i;
    logic        tx_done;
    logic        q0_rden, q1_rden, q2_rden, q3_rden;
    logic [7:0]  md_o;
    logic        md_wr_o;
    logic [1:0]  qid_o;
    logic        busy;
    logic        terr;
    logic [15:0] c0, c1, c2, c3;
    logic [3:0]  rden;

    int checks = 0;
    int failures = 0;

    logic [15:0] cnt_m [4];
    logic        terr_m;
    logic [7:0]  md_m;
    logic [1:0]  qid_m;

    int cyc = 0;
    int last_rd = -100;

    ts #(.MD_TIMEOUT(MDT), .PLATFORM("xilinx")) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_ts_fifo_empty   (empty),
        .in_ts_gate_state   (gate),
        .in_ts_md           (md_i),
        .in_ts_md_wr        (md_wr_i),
        .out_ts_q0_rden     (q0_rden),
        .out_ts_q1_rden     (q1_rden),
        .out_ts_q2_rden     (q2_rden),
        .out_ts_q3_rden     (q3_rden),
        .out_ts_md          (md_o),
        .out_ts_md_wr       (md_wr_o),
        .out_ts_qid         (qid_o),
        .in_ts_tx_done      (tx_done),
        .out_ts_busy        (busy),
        .out_ts_timeout_err (terr),
        .out_ts_q0_deq_cnt  (c0),
        .out_ts_q1_deq_cnt  (c1),
        .out_ts_q2_deq_cnt  (c2),
        .out_ts_q3_deq_cnt  (c3)
    );

    assign rden = {q3_rden, q2_rden, q1_rden, q0_rden};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-enable hygiene over the whole run: one-hot and rounds >= 3 apart.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rd = -100;
        end else begin
            chk("rden_onehot", 32'($countones(rden) <= 1), 1);
            if (|rden) begin
                chk("rden_gap", 32'((cyc - last_rd) >= 3), 1);
                last_rd = cyc;
            end
        end
    end

    task automatic chk_held();
        chk("md", md_o, md_m);
        chk("qid", qid_o, qid_m);
        chk("terr", terr, terr_m);
        chk("cnt0", c0, cnt_m[0]);
        chk("cnt1", c1, cnt_m[1]);
        chk("cnt2", c2, cnt_m[2]);
        chk("cnt3", c3, cnt_m[3]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) cnt_m[i] = 16'd0;
        terr_m = 1'b0;
        md_m   = 8'd0;
        qid_m  = 2'd0;
    endtask

    // One scheduling opportunity, entered at posedge+1 with the DUT in IDLE.
    task automatic do_round(input logic [3:0] g, input logic [3:0] e,
                            input bit tmo, input logic [7:0] md,
                            input int d);
        logic [3:0] elig;
        int gr;
        gate    = g;
        empty   = e;
        md_wr_i = 1'($urandom);
        md_i    = 8'($urandom);
        tx_done = 1'($urandom);
        @(negedge clk);
        elig = g & ~e;
        gr = -1;
        for (int i = 3; i >= 0; i--) if (elig[i]) gr = i;
        chk("rden_idle", rden, (gr < 0) ? 0 : (1 << gr));
        chk("busy_idle", busy, 0);
        chk("mdwr_idle", md_wr_o, 0);
        chk_held();
        @(posedge clk); #1;
        if (gr < 0) return;
        gate    = 4'($urandom);
        empty   = 4'($urandom);
        md_wr_i = !tmo;
        md_i    = md;
        tx_done = 1'($urandom);
        @(negedge clk);
        chk("rden_wmd", rden, 0);
        chk("busy_wmd", busy, 1);
        if (tmo) begin
            for (int k = 1; k < MDT; k++) begin
                @(posedge clk); #1;
                md_wr_i = 1'b0;
                md_i    = 8'($urandom);
                @(negedge clk);
                chk("busy_tmo", busy, 1);
                chk("rden_tmo", rden, 0);
                chk_held();
            end
            @(posedge clk); #1;
            terr_m = 1'b1;
            return;
        end
        @(posedge clk); #1;
        md_wr_i = 1'($urandom);
        md_i    = 8'($urandom);
        tx_done = (d == 0);
        cnt_m[gr] = cnt_m[gr] + 16'd1;
        md_m  = md;
        qid_m = 2'(gr);
        @(negedge clk);
        chk("mdwr_pulse", md_wr_o, 1);
        chk("busy_wd", busy, 1);
        chk("rden_wd", rden, 0);
        chk_held();
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            tx_done = (k == d);
            md_wr_i = 1'($urandom);
            @(negedge clk);
            chk("mdwr_low", md_wr_o, 0);
            chk("busy_hold", busy, 1);
            chk("rden_hold", rden, 0);
            chk_held();
        end
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    initial begin
        gate    = 4'h0;
        empty   = 4'hF;
        md_i    = 8'h00;
        md_wr_i = 1'b0;
        tx_done = 1'b0;
        clear_model();
        #12;
        chk("rst_rden", rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mdwr", md_wr_o, 0);
        chk_held();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_round(4'hF, 4'b1011, 0, 8'h5A, 2);
        do_round(4'b1110, 4'h0, 0, 8'h11, 0);
        do_round(4'b1110, 4'h0, 0, 8'h22, 1);
        for (int i = 0; i < 3; i++) do_round(4'b1000, 4'h0, 0, 8'($urandom), i);
        do_round(4'hF, 4'hE, 1, 8'h00, 0);
        do_round(4'hF, 4'hE, 0, 8'hC3, 1);

        for (int r = 0; r < 250; r++) begin
            do_round(4'($urandom), 4'($urandom), ($urandom % 8) == 0,
                     8'($urandom), int'($urandom % 4));
        end

        // Reset in the middle of a round.
        gate    = 4'hF;
        empty   = 4'h0;
        md_wr_i = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        chk("mid_rden", rden, 1);
        @(posedge clk); #1;
        md_wr_i = 1'b1;
        md_i    = 8'h77;
        @(posedge clk); #1;
        md_wr_i = 1'b0;
        cnt_m[0] = cnt_m[0] + 16'd1;
        md_m  = 8'h77;
        qid_m = 2'd0;
        @(negedge clk);
        chk("mid_pulse", md_wr_o, 1);
        chk_held();
        #2;
        empty = 4'hF;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mdwr", md_wr_o, 0);
        chk("mid_rst_rden", rden, 0);
        chk_held();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_round(4'hF, 4'b0111, 0, 8'hA5, 0);
        do_round(4'hF, 4'b0111, 0, 8'h5A, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
